uart_tx_multi: RTL

UART_TX_MULTI -- requirements
Module: uart_tx_multi

---
 rtl/uart_tx_multi.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_multi.sv
// Multi-channel UART transmitter: per-channel FIFO and frame FSM sharing one baud tick.
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx_multi #(
  parameter int NUM_CH        = 2,
  parameter int DATA_BITS     = 8,
  parameter int STOP_TICK     = 16,
  parameter int N             = 10,
  parameter int COUNT         = 651,
  parameter int ADDR_SIZE_EXP = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             wr,
  input  logic [NUM_CH*DATA_BITS-1:0]   wr_data,
  input  logic [NUM_CH-1:0]             tx_en,
  output logic [NUM_CH-1:0]             full,
  output logic [NUM_CH-1:0]             empty,
  output logic [NUM_CH-1:0]             busy,
  output logic [NUM_CH-1:0]             tx_done,
  output logic [NUM_CH-1:0]             tx
);

  localparam int DEPTH = 2**ADDR_SIZE_EXP;
  localparam int AW    = ADDR_SIZE_EXP + 1;
  localparam int TMAX  = (STOP_TICK > 16) ? STOP_TICK : 16;
  localparam int TW    = $clog2(TMAX);
  localparam int BW    = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [N-1:0]           baud_q, baud_d;
  logic                   tick;

  logic [DATA_BITS-1:0]   mem_q   [NUM_CH][DEPTH];
  logic [AW-1:0]          wptr_q  [NUM_CH];
  logic [AW-1:0]          wptr_d  [NUM_CH];
  logic [AW-1:0]          rptr_q  [NUM_CH];
  logic [AW-1:0]          rptr_d  [NUM_CH];
  logic [DATA_BITS-1:0]   head    [NUM_CH];
  logic [NUM_CH-1:0]      push, pop;

  state_t                 state_q [NUM_CH];
  state_t                 state_d [NUM_CH];
  logic [TW-1:0]          tcnt_q  [NUM_CH];
  logic [TW-1:0]          tcnt_d  [NUM_CH];
  logic [BW-1:0]          bcnt_q  [NUM_CH];
  logic [BW-1:0]          bcnt_d  [NUM_CH];
  logic [DATA_BITS-1:0]   shreg_q [NUM_CH];
  logic [DATA_BITS-1:0]   shreg_d [NUM_CH];
`ifdef UART_TX_PARITY_EN
  logic [NUM_CH-1:0]      par_q, par_d;
`endif

  assign tick = (baud_q == N'(COUNT - 1));

  always_comb begin
    baud_d = tick ? '0 : baud_q + 1'b1;
  end

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      empty[k] = (wptr_q[k] == rptr_q[k]);
      full[k]  = (wptr_q[k][AW-1] != rptr_q[k][AW-1]) &&
                 (wptr_q[k][AW-2:0] == rptr_q[k][AW-2:0]);
      head[k]  = mem_q[k][rptr_q[k][AW-2:0]];
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      push[k]   = wr[k] && (!full[k] || pop[k]);
      wptr_d[k] = wptr_q[k] + AW'(push[k]);
      rptr_d[k] = rptr_q[k] + AW'(pop[k]);
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      state_d[k] = state_q[k];
      tcnt_d[k]  = tcnt_q[k];
      bcnt_d[k]  = bcnt_q[k];
      shreg_d[k] = shreg_q[k];
`ifdef UART_TX_PARITY_EN
      par_d[k]   = par_q[k];
`endif
      pop[k]     = 1'b0;
      tx_done[k] = 1'b0;
      tx[k]      = 1'b1;
      busy[k]    = (state_q[k] != IDLE);
      case (state_q[k])
        IDLE: begin
          if (tx_en[k] && !empty[k]) begin
            pop[k]     = 1'b1;
            shreg_d[k] = head[k];
`ifdef UART_TX_PARITY_EN
            par_d[k]   = ^head[k];
`endif
            tcnt_d[k]  = '0;
            bcnt_d[k]  = '0;
            state_d[k] = START;
          end
        end
        START: begin
          tx[k] = 1'b0;
          if (tick) begin
            if (tcnt_q[k] == TW'(15)) begin
              tcnt_d[k]  = '0;
              state_d[k] = DATA;
            end else begin
              tcnt_d[k] = tcnt_q[k] + 1'b1;
            end
          end
        end
        DATA: begin
          tx[k] = shreg_q[k][0];
          if (tick) begin
            if (tcnt_q[k] == TW'(15)) begin
              tcnt_d[k]  = '0;
              shreg_d[k] = shreg_q[k] >> 1;
              if (bcnt_q[k] == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                state_d[k] = PARITY;
`else
                state_d[k] = STOP;
`endif
              end else begin
                bcnt_d[k] = bcnt_q[k] + 1'b1;
              end
            end else begin
              tcnt_d[k] = tcnt_q[k] + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx[k] = par_q[k];
          if (tick) begin
            if (tcnt_q[k] == TW'(15)) begin
              tcnt_d[k]  = '0;
              state_d[k] = STOP;
            end else begin
              tcnt_d[k] = tcnt_q[k] + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (tcnt_q[k] == TW'(STOP_TICK - 1)) begin
              tcnt_d[k]  = '0;
              tx_done[k] = 1'b1;
              state_d[k] = IDLE;
            end else begin
              tcnt_d[k] = tcnt_q[k] + 1'b1;
            end
          end
        end
        default: state_d[k] = IDLE;
      endcase
    end
  end

  // Storage is not reset; clearing the pointers discards queued words.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (push[k]) mem_q[k][wptr_q[k][AW-2:0]] <= wr_data[k*DATA_BITS +: DATA_BITS];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_q <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        wptr_q[k]  <= '0;
        rptr_q[k]  <= '0;
        state_q[k] <= IDLE;
        tcnt_q[k]  <= '0;
        bcnt_q[k]  <= '0;
        shreg_q[k] <= '0;
      end
`ifdef UART_TX_PARITY_EN
      par_q <= '0;
`endif
    end else begin
      baud_q <= baud_d;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        wptr_q[k]  <= wptr_d[k];
        rptr_q[k]  <= rptr_d[k];
        state_q[k] <= state_d[k];
        tcnt_q[k]  <= tcnt_d[k];
        bcnt_q[k]  <= bcnt_d[k];
        shreg_q[k] <= shreg_d[k];
      end
`ifdef UART_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end

endmodule
